mdu_iter: RTL and testbench

- Multi-cycle multiply/divide unit with HI/LO registers for the MIPS datapath.
- It is the sequential counterpart to the single-cycle ALU. The E stage drives it with the same SrcA/SrcB operand pair plus an op code.
- It returns results only after a fixed latency, under a start/busy handshake.
- Stall logic reads `busy`. The mfhi/mflo datapath reads HI/LO.

---
 rtl/mdu_iter.sv | 178 +++++++++++++++++
 tb/tb_mdu_iter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mdu_iter.sv
// mdu_iter: multi-cycle MIPS multiply/divide unit with HI/LO registers and a start/busy handshake.
// Optional MADD accumulate (MDUOp=6) is built only when MDU_MADD_EN is defined.
module mdu_iter #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  MDUOp,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
`ifdef MDU_MADD_EN
  localparam logic [2:0] OP_MADD  = 3'd6;
`endif

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    op_q, op_d;
  logic [31:0]   a_q, a_d, b_q, b_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic          is_mul, is_div;
  logic          res_we;
  logic [31:0]   res_hi, res_lo;

  function automatic logic [63:0] mul_s(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] ae, be;
    ae = {{32{a[31]}}, a};
    be = {{32{b[31]}}, b};
    return ae * be;
  endfunction

  function automatic logic [63:0] mul_u(input logic [31:0] a, input logic [31:0] b);
    return {32'd0, a} * {32'd0, b};
  endfunction

  // Returns {remainder, quotient}; a zero divisor is replaced so the divider never sees it.
  function automatic logic [63:0] div_u(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] d;
    d = (b == 32'd0) ? 32'd1 : b;
    return {a % d, a / d};
  endfunction

  // Sign-magnitude divide: quotient truncates toward zero, remainder follows the dividend.
  // The 0x80000000 / -1 overflow falls out naturally as quotient 0x80000000, remainder 0.
  function automatic logic [63:0] div_s(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] am, bm, q, r;
    logic [63:0] qr;
    am = a[31] ? (32'd0 - a) : a;
    bm = b[31] ? (32'd0 - b) : b;
    qr = div_u(am, bm);
    q  = qr[31:0];
    r  = qr[63:32];
    if (a[31] ^ b[31]) q = 32'd0 - q;
    if (a[31])         r = 32'd0 - r;
    return {r, q};
  endfunction

  always_comb begin
    is_mul = (MDUOp == OP_MULT) || (MDUOp == OP_MULTU);
`ifdef MDU_MADD_EN
    is_mul = is_mul || (MDUOp == OP_MADD);
`endif
    is_div = (MDUOp == OP_DIV) || (MDUOp == OP_DIVU);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
    op_q <= op_d;
    a_q  <= a_d;
    b_q  <= b_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (is_mul || is_div) begin
            state_d = RUN;
            cnt_d   = is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            op_d    = MDUOp;
            a_d     = SrcA;
            b_d     = SrcB;
          end else if (MDUOp == OP_MTHI) begin
            hi_d = SrcA;
          end else if (MDUOp == OP_MTLO) begin
            lo_d = SrcA;
          end
        end
      end
      RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          if (res_we) begin
            hi_d = res_hi;
            lo_d = res_lo;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    logic [63:0] r64;
    r64    = 64'd0;
    res_we = 1'b0;
    case (op_q)
      OP_MULT: begin
        r64    = mul_s(a_q, b_q);
        res_we = 1'b1;
      end
      OP_MULTU: begin
        r64    = mul_u(a_q, b_q);
        res_we = 1'b1;
      end
      OP_DIV: begin
        r64    = div_s(a_q, b_q);
        res_we = (b_q != 32'd0);
      end
      OP_DIVU: begin
        r64    = div_u(a_q, b_q);
        res_we = (b_q != 32'd0);
      end
`ifdef MDU_MADD_EN
      OP_MADD: begin
        r64    = {hi_q, lo_q} + mul_s(a_q, b_q);
        res_we = 1'b1;
      end
`endif
      default: begin
        r64    = 64'd0;
        res_we = 1'b0;
      end
    endcase
    res_hi = r64[63:32];
    res_lo = r64[31:0];
  end

  assign busy = (state_q == RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed scoreboard bench for mdu_iter: latency, HI/LO results, div-by-zero, busy protection, MADD.
module tb_mdu_iter;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  MDUOp;
  logic [31:0] SrcA, SrcB;
  logic        busy;
  logic [31:0] HI, LO;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] hi_m, lo_m;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  mdu_iter #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .MDUOp(MDUOp),
    .SrcA(SrcA), .SrcB(SrcB), .busy(busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] hi, input logic [31:0] lo, input int cyc);
    exp_t e;
    e.tag = tag; e.hi = hi; e.lo = lo; e.cyc = cyc;
    sb.push_back(e);
  endtask

  // Drives one request for a single edge, then scrambles the operands to prove they were latched.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; MDUOp = op; SrcA = a; SrcB = b;
    tick();
    start = 1'b0; MDUOp = 3'd7; SrcA = $urandom; SrcB = $urandom;
  endtask

  task automatic complete(input int n);
    exp_t e;
    check("sb_depth", 32'(sb.size()), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({e.tag, "_busy_cycles"}, 32'(n), 32'(e.cyc));
      check({e.tag, "_hi"}, HI, e.hi);
      check({e.tag, "_lo"}, LO, e.lo);
      hi_m = e.hi;
      lo_m = e.lo;
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    issue(op, a, b);
    check("run_hi_held", HI, hi_m);
    check("run_lo_held", LO, lo_m);
    n = 0;
    while (busy && n < 200) begin
      n++;
      tick();
    end
    complete(n);
  endtask

  task automatic mt(input logic [2:0] op, input logic [31:0] v);
    issue(op, v, 32'd0);
    if (op == 3'd4) hi_m = v; else lo_m = v;
    check("mt_busy", {31'd0, busy}, 32'd0);
    check("mt_hi", HI, hi_m);
    check("mt_lo", LO, lo_m);
  endtask

  initial begin
    int n;
    reset = 1'b0; start = 1'b0; MDUOp = 3'd0; SrcA = 32'd0; SrcB = 32'd0;
    tick();
    tick();
    reset = 1'b1;
    hi_m = 32'd0; lo_m = 32'd0;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);

    // Abort a MULT with reset on its third busy cycle.
    issue(3'd0, 32'd3, 32'hFFFFFFFE);
    check("abort_busy1", {31'd0, busy}, 32'd1);
    tick();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi", HI, 32'd0);
    check("abort_lo", LO, 32'd0);
    repeat (8) tick();
    check("abort_late_busy", {31'd0, busy}, 32'd0);
    check("abort_late_hi", HI, 32'd0);
    check("abort_late_lo", LO, 32'd0);

    push("mult", 32'hFFFFFFFF, 32'hFFFFFFFA, 5);
    run_op(3'd0, 32'hFFFFFFFE, 32'd3);
    push("multu", 32'h00000002, 32'hFFFFFFFA, 5);
    run_op(3'd1, 32'hFFFFFFFE, 32'd3);
    push("div_neg", 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    run_op(3'd2, 32'hFFFFFFF9, 32'd2);
    push("divu", 32'd1, 32'd3, 10);
    run_op(3'd3, 32'd7, 32'd2);
    push("div_negdivisor", 32'd1, 32'hFFFFFFFD, 10);
    run_op(3'd2, 32'd7, 32'hFFFFFFFE);
    push("div_ovf", 32'd0, 32'h80000000, 10);
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF);

    // Divide by zero keeps HI/LO.
    mt(3'd4, 32'hAAAA0000);
    mt(3'd5, 32'h0000BBBB);
    push("divu_zero", 32'hAAAA0000, 32'h0000BBBB, 10);
    run_op(3'd3, 32'd5, 32'd0);

    // Requests while busy are dropped.
    push("busy_prot", 32'd0, 32'd6, 5);
    issue(3'd0, 32'd2, 32'd3);
    n = 0;
    if (busy) n++;
    tick();
    if (busy) n++;
    start = 1'b1; MDUOp = 3'd5; SrcA = 32'd99; SrcB = 32'd0;
    tick();
    if (busy) n++;
    start = 1'b1; MDUOp = 3'd2; SrcA = 32'd100; SrcB = 32'd7;
    tick();
    start = 1'b0; MDUOp = 3'd7;
    while (busy && n < 200) begin
      n++;
      tick();
    end
    complete(n);
    mt(3'd5, 32'd99);

    // Reserved op is a no-op.
    issue(3'd7, 32'h12345678, 32'h1);
    check("rsvd_busy", {31'd0, busy}, 32'd0);
    tick();
    check("rsvd_hi", HI, hi_m);
    check("rsvd_lo", LO, lo_m);

    mt(3'd4, 32'd0);
    mt(3'd5, 32'hFFFFFFFF);
`ifdef MDU_MADD_EN
    push("madd", 32'd1, 32'd0, 5);
    run_op(3'd6, 32'd1, 32'd1);
`else
    issue(3'd6, 32'd1, 32'd1);
    n = 0;
    repeat (6) begin
      if (busy) n++;
      tick();
    end
    check("madd_off_busy_cycles", 32'(n), 32'd0);
    check("madd_off_hi", HI, 32'd0);
    check("madd_off_lo", LO, 32'hFFFFFFFF);
`endif

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
